// File: rtl/field_table_parse_arbiter.sv
// Shares one header parser among NUM frame sources, one grant per frame.
// FIELD_TABLE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module field_table_parse_arbiter #(
   parameter int NUM       = 4,
   parameter int DSIZE     = 8,
   parameter int FIELD_LEN = 16
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic [NUM-1:0]             s_tvalid,
   input  logic [NUM*DSIZE-1:0]       s_tdata,
   input  logic [NUM-1:0]             s_tlast,
   output logic [NUM-1:0]             s_tready,
   output logic                       m_tvalid,
   output logic [DSIZE-1:0]           m_tdata,
   output logic                       m_tlast,
   input  logic                       m_tready,
   output logic [FIELD_LEN*DSIZE-1:0] field_value,
   output logic [$clog2(NUM)-1:0]     field_id,
   output logic                       field_short,
   output logic                       field_valid,
   input  logic                       field_ready
);

   localparam int IW = $clog2(NUM);
   localparam int CW = $clog2(FIELD_LEN + 1);
   localparam int FW = FIELD_LEN * DSIZE;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      RESULT,
      PAYLOAD
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [FW-1:0]   value_q, value_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            short_q, short_d;
   logic            open_q, open_d;
   logic [IW-1:0]   pick;
   logic [DSIZE-1:0] gdata;
   logic            gvalid;
   logic            glast;

   assign gdata  = s_tdata[int'(grant_q)*DSIZE +: DSIZE];
   assign gvalid = s_tvalid[grant_q];
   assign glast  = s_tlast[grant_q];

`ifdef FIELD_TABLE_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (s_tvalid[i]) pick = IW'(i);
      end
   end
`else
   logic [IW-1:0] rr_q;
   logic          found;
   int            idx;

   // Search starts at the source after the last one granted.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM; i++) begin
         idx = (int'(rr_q) + i) % NUM;
         if (!found && s_tvalid[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else if (state_q == IDLE && |s_tvalid) begin
         rr_q <= IW'((int'(pick) + 1) % NUM);
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      value_d  = value_q;
      cnt_d    = cnt_q;
      short_d  = short_q;
      open_d   = open_q;
      s_tready = '0;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      field_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|s_tvalid) begin
               grant_d = pick;
               value_d = '0;
               cnt_d   = '0;
               short_d = 1'b0;
               open_d  = 1'b0;
               state_d = HEADER;
            end
         end
         HEADER: begin
            s_tready[grant_q] = 1'b1;
            if (gvalid) begin
               for (int k = 0; k < FIELD_LEN; k++) begin
                  if (cnt_q == CW'(k))
                     value_d[(FIELD_LEN-1-k)*DSIZE +: DSIZE] = gdata;
               end
               cnt_d = cnt_q + 1'b1;
               if (glast) begin
                  short_d = (cnt_q != CW'(FIELD_LEN - 1));
                  open_d  = 1'b0;
                  state_d = RESULT;
               end else if (cnt_q == CW'(FIELD_LEN - 1)) begin
                  short_d = 1'b0;
                  open_d  = 1'b1;
                  state_d = RESULT;
               end
            end
         end
         RESULT: begin
            field_valid = 1'b1;
            if (field_ready) state_d = open_q ? PAYLOAD : IDLE;
         end
         PAYLOAD: begin
            m_tvalid = gvalid;
            m_tdata  = gdata;
            m_tlast  = glast;
            s_tready[grant_q] = m_tready;
            if (gvalid && m_tready && glast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         value_q <= '0;
         cnt_q   <= '0;
         short_q <= 1'b0;
         open_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         value_q <= value_d;
         cnt_q   <= cnt_d;
         short_q <= short_d;
         open_q  <= open_d;
      end
   end

   assign field_value = value_q;
   assign field_id    = grant_q;
   assign field_short = short_q;

endmodule

// File: tb/tb_field_table_parse_arbiter.sv
// Directed bench for field_table_parse_arbiter (NUM=4, DSIZE=8, FIELD_LEN=16).
// Inputs change 1ns after posedge; outputs sampled 1ns before posedge.
module tb_field_table_parse_arbiter;

   logic         clock;
   logic         rst_n;
   logic [3:0]   s_tvalid;
   logic [31:0]  s_tdata;
   logic [3:0]   s_tlast;
   logic [3:0]   s_tready;
   logic         m_tvalid;
   logic [7:0]   m_tdata;
   logic         m_tlast;
   logic         m_tready;
   logic [127:0] field_value;
   logic [1:0]   field_id;
   logic         field_short;
   logic         field_valid;
   logic         field_ready;

   field_table_parse_arbiter #(
      .NUM(4), .DSIZE(8), .FIELD_LEN(16)
   ) dut (
      .clock(clock), .rst_n(rst_n),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata),
      .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata),
      .m_tlast(m_tlast), .m_tready(m_tready),
      .field_value(field_value), .field_id(field_id),
      .field_short(field_short), .field_valid(field_valid),
      .field_ready(field_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int         total = 0;
   int         bad = 0;
   int         pos[4];
   int         len[4];
   int         rep[4];
   logic [7:0] base[4];
   logic [3:0] en;
   logic       mt_tog;
   int         bus_err = 0;

   logic [7:0]   mq[$];
   logic         mlq[$];
   logic [127:0] fvq[$];
   logic [1:0]   fiq[$];
   logic         fsq[$];

   always_comb begin
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      for (int i = 0; i < 4; i++) begin
         s_tvalid[i] = en[i] && (pos[i] < len[i]);
         s_tdata[i*8 +: 8] = base[i] + 8'(pos[i]);
         s_tlast[i] = (pos[i] == len[i] - 1);
      end
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] hdr(input logic [7:0] b, input int n);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[127-8*k -: 8] = b + 8'(k);
      return v;
   endfunction

   function automatic logic [127:0] mpack();
      logic [127:0] v;
      v = '0;
      foreach (mq[i]) v = {v[119:0], mq[i]};
      return v;
   endfunction

   function automatic logic [15:0] lpack();
      logic [15:0] v;
      v = '0;
      foreach (mlq[i]) v = {v[14:0], mlq[i]};
      return v;
   endfunction

   function automatic bit alldone();
      for (int i = 0; i < 4; i++)
         if (en[i] && (pos[i] < len[i] || rep[i] > 0)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clrq();
      mq.delete();
      mlq.delete();
      fvq.delete();
      fiq.delete();
      fsq.delete();
   endtask

   task automatic quiet();
      for (int i = 0; i < 4; i++) begin
         pos[i] = 0;
         len[i] = 0;
         rep[i] = 0;
         base[i] = '0;
      end
      en = '0;
   endtask

   task automatic src(input int i, input int n, input logic [7:0] b,
                      input int r);
      base[i] = b;
      len[i]  = n;
      rep[i]  = r;
      pos[i]  = 0;
      en[i]   = 1'b1;
   endtask

   task automatic cyc();
      logic [3:0] hs;
      #8;
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
         mq.push_back(m_tdata);
         mlq.push_back(m_tlast);
      end
      if (field_valid && field_ready) begin
         fvq.push_back(field_value);
         fiq.push_back(field_id);
         fsq.push_back(field_short);
      end
      if ($countones(s_tready) > 1) bus_err++;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (hs[i]) begin
            pos[i]++;
            if (pos[i] == len[i] && rep[i] > 0) begin
               rep[i]--;
               pos[i] = 0;
            end
         end
      end
      if (mt_tog) m_tready = ~m_tready;
   endtask

   task automatic run(input string tag, input int max);
      int n;
      n = 0;
      while (!alldone() && n < max) begin
         cyc();
         n++;
      end
      repeat (4) cyc();
      chk(tag, 128'(n < max), 128'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      quiet();
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      clrq();
   endtask

   logic [127:0] e;
   logic [127:0] cap;
   int           ids[5];
   int           hold_err;

   initial begin
      rst_n = 1'b0;
      m_tready = 1'b1;
      field_ready = 1'b1;
      mt_tog = 1'b0;
      quiet();
      clrq();
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("rst_valid", 128'(field_valid), 128'd0);
      chk("rst_sready", 128'(s_tready), 128'd0);
      chk("rst_mvalid", 128'({m_tvalid, m_tlast}), 128'd0);
      chk("rst_value", field_value, 128'd0);
      chk("rst_id", 128'({field_id, field_short}), 128'd0);
      rst_n = 1'b1;

      // 20-beat frame on source 0
      src(0, 20, 8'h00, 0);
      run("t1_tmo", 60);
      chk("t1_nres", 128'(fvq.size()), 128'd1);
      chk("t1_value", fvq[0], hdr(8'h00, 16));
      chk("t1_id_short", 128'({fiq[0], fsq[0]}), 128'd0);
      chk("t1_pay", mpack(), 128'h10111213);
      chk("t1_last", 128'(lpack()), 128'b0001);
      chk("t1_persist", field_value, hdr(8'h00, 16));
      quiet();
      clrq();

      // short 5-beat frame on source 2
      src(2, 5, 8'hA1, 0);
      run("t2_tmo", 40);
      chk("t2_value", fvq[0], hdr(8'hA1, 5));
      chk("t2_id_short", 128'({fiq[0], fsq[0]}), 128'b101);
      chk("t2_nopay", 128'(mq.size()), 128'd0);
      quiet();
      clrq();

      // tlast exactly on the last header beat
      src(1, 16, 8'h30, 0);
      run("t3_tmo", 40);
      chk("t3_value", fvq[0], hdr(8'h30, 16));
      chk("t3_id_short", 128'({fiq[0], fsq[0]}), 128'b010);
      chk("t3_nopay", 128'(mq.size()), 128'd0);

      // all sources requesting, source 0 sends two frames
      do_reset();
      for (int i = 0; i < 4; i++) src(i, 18, 8'(i * 8'h40), (i == 0) ? 1 : 0);
      run("t4_tmo", 400);
`ifdef FIELD_TABLE_ARB_FIXED_PRIO_EN
      ids = '{0, 0, 1, 2, 3};
`else
      ids = '{0, 1, 2, 3, 0};
`endif
      chk("t4_nres", 128'(fvq.size()), 128'd5);
      e = '0;
      for (int k = 0; k < 5; k++) begin
         if (k < fiq.size()) chk("t4_id", 128'(fiq[k]), 128'(ids[k]));
         e = {e[111:0], 8'(ids[k] * 8'h40 + 16), 8'(ids[k] * 8'h40 + 17)};
      end
      chk("t4_pay", mpack(), e);
      chk("t4_val2", fvq[2], hdr(8'(ids[2] * 8'h40), 16));
      quiet();
      clrq();

      // result held by field_ready, then throttled payload
      field_ready = 1'b0;
      src(3, 20, 8'hC0, 0);
      for (int n = 0; n < 40 && !field_valid; n++) cyc();
      chk("t5_valid", 128'(field_valid), 128'd1);
      cap = field_value;
      hold_err = 0;
      for (int n = 0; n < 10; n++) begin
         cyc();
         if (s_tready != 4'b0 || !field_valid || field_value != cap)
            hold_err++;
      end
      chk("t5_hold", 128'(hold_err), 128'd0);
      chk("t5_value", cap, hdr(8'hC0, 16));
      chk("t5_id", 128'({field_id, field_short}), 128'b110);
      field_ready = 1'b1;
      mt_tog = 1'b1;
      run("t5_tmo", 60);
      mt_tog = 1'b0;
      m_tready = 1'b1;
      chk("t5_pay", mpack(), 128'hD0D1D2D3);
      chk("t5_last", 128'(lpack()), 128'b0001);

      // asynchronous reset in the middle of the header
      quiet();
      clrq();
      src(1, 20, 8'h50, 0);
      for (int n = 0; n < 40 && pos[1] != 7; n++) cyc();
      chk("t6_beat7", 128'(pos[1]), 128'd7);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out", 128'({field_valid, s_tready, m_tvalid, m_tlast}),
          128'd0);
      chk("t6_rst_val", field_value, 128'd0);
      chk("t6_rst_id", 128'({field_id, field_short}), 128'd0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      quiet();
      clrq();
      repeat (3) cyc();
      chk("t6_nores", 128'(fvq.size()), 128'd0);

      src(1, 20, 8'h60, 0);
      run("t7_tmo", 60);
      chk("t7_nres", 128'(fvq.size()), 128'd1);
      chk("t7_value", fvq[0], hdr(8'h60, 16));
      chk("t7_id_short", 128'({fiq[0], fsq[0]}), 128'b010);
      chk("t7_pay", mpack(), 128'h70717273);
      chk("onehot_ready", 128'(bus_err), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/field_table_parse_arbiter.md
Name: field_table_parse_arbiter

Overview:
- Shares one big-field header parser among NUM AXI-stream frame sources.
- Grants one source per whole frame and captures its first FIELD_LEN beats as a header value.
- Presents the header with the source id on a result handshake, then forwards the rest of the frame to a single payload master.
- Sits in front of common_frame_table consumers, replacing per-source parser instances.

Parameters:
NUM, 4, number of requesting slave streams (2..16)
DSIZE, 8, beat data width in bits
FIELD_LEN, 16, header length in beats (1..128)

Ports:
clock  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
s_tvalid  input  NUM  per-source beat valid
s_tdata  input  NUM*DSIZE  per-source data; source i at [i*DSIZE +: DSIZE]
s_tlast  input  NUM  per-source end of frame
s_tready  output  NUM  per-source ready; only granted bit may be 1
m_tvalid  output  1  payload beat valid
m_tdata  output  DSIZE  payload data
m_tlast  output  1  payload end of frame
m_tready  input  1  downstream ready
field_value  output  FIELD_LEN*DSIZE  header; beat 0 at MSB [FIELD_LEN*DSIZE-1 -: DSIZE]
field_id  output  $clog2(NUM)  granted source index
field_short  output  1  frame ended before FIELD_LEN beats
field_valid  output  1  header result valid
field_ready  input  1  result consumer ready

Behaviour:
- Reset: state IDLE; s_tready, m_tvalid, m_tlast, field_valid, field_short = 0; field_value, field_id, beat count = 0; round-robin pointer = 0.
- States: IDLE, HEADER, RESULT, PAYLOAD.
- IDLE:
  - If any s_tvalid, register the grant next cycle and go to HEADER.
  - Round-robin: search starts at last granted + 1, wrapping modulo NUM.
  - Clear field_value to 0 and the beat count to 0 on the same edge.
- HEADER:
  - s_tready[g] = 1 combinationally while in this state.
  - Each accepted beat k stores at slot k and increments the count.
  - On beat FIELD_LEN-1 without tlast, go to RESULT with field_short = 0 and frame open.
  - On tlast at beat k < FIELD_LEN-1, go to RESULT with field_short = 1; unfilled slots stay 0.
  - tlast exactly on beat FIELD_LEN-1 gives field_short = 0, frame closed.
- RESULT:
  - field_valid = 1; field_value, field_id and field_short stay stable until field_ready.
  - All s_tready = 0 (source stalls).
  - On field_valid && field_ready: go to PAYLOAD if the frame is open, else IDLE.
- PAYLOAD:
  - m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], m_tlast = s_tlast[g], s_tready[g] = m_tready.
  - This path is combinational, zero latency, and m_tvalid never depends on m_tready.
  - A beat accepted with tlast goes to IDLE.
  - Payload beats are never counted and payload length is unbounded.
- Grant changes only in IDLE; a source dropping s_tvalid mid-frame keeps its grant (bubble).
- Minimum overhead per frame: 1 IDLE cycle plus 1 RESULT cycle (field_ready tied high).
- field_value and field_id persist after RESULT until the next grant clears them.
- Reset mid-frame aborts immediately; no partial result is emitted after reset.

Optional Feature:
- FIELD_TABLE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins, round-robin pointer removed.
- Undefined (default): round-robin as above.

Test Plan:
- Single source 0, FIELD_LEN=16, 20-beat frame bytes 0x00..0x13 -> field_valid with field_value = 0x000102…0F, field_id = 0, field_short = 0; m receives 0x10..0x13, m_tlast on 0x13.
- Source 2, 5-beat frame 0xA1..0xA5 with tlast -> field_short = 1, value = A1A2A3A4A5 followed by 11 zero bytes, field_id = 2; no m_tvalid; returns to IDLE.
- 16-beat frame with tlast on beat 15 -> field_short = 0, straight to IDLE after handshake, no payload beats.
- Sources 0..3 all valid, back-to-back 18-beat frames -> field_id sequence 0,1,2,3,0; with the macro defined -> 0,0,0 while source 0 keeps requesting.
- field_ready held low 10 cycles, then m_tready toggled 1/0 -> all s_tready = 0 during the hold; result stable; payload order preserved with no beat loss or duplication.
- rst_n asserted at header beat 7 -> all outputs at reset values asynchronously; after release, a new 20-beat frame parses correctly.
